demux1x4_burst_router: RTL and testbench
========================================

# demux1x4_burst_router

Sequential 1-to-4 demultiplexer: the distribution end of the 4:1 decoder/tri-state selection path. A single valid/ready input stream is routed to one of four output lanes, chosen by a 2-bit select. The select is latched on the first beat of a burst and held until the burst ends. Output is one registered stage with full-throughput backpressure, plus per-lane delivered-beat counters and a burst-overrun flag.

## Interface
- DW, 8, data width of the stream
- BURST_MAX, 15, maximum beats per burst (1..255); the beat that reaches it terminates the burst
- CNT_W, 8, width of each per-lane delivered-beat counter
---
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  input beat present
- in_ready  output  1  router can accept a beat this cycle
- in_data  input  DW  input payload
- in_sel  input  2  lane select {a,b}; sampled only on the first beat of a burst
- in_last  input  1  marks the final beat of a burst
- out_valid  output  4  one-hot lane valid; bit k means out_data belongs to lane k
- out_ready  input  4  per-lane sink ready
- out_data  output  DW  shared registered payload
- out_last  output  1  registered copy of the burst-terminating flag
- burst_err  output  1  one-cycle pulse when a burst is force-terminated at BURST_MAX
- lane_cnt  output  4*CNT_W  per-lane delivered-beat counters, saturating; lane k occupies bits [k*CNT_W +: CNT_W]

## Operation
- **Accept:** a beat is accepted when in_valid && in_ready.
- **Output register valid (ov):** ov = |out_valid.
- **Drain:** a drain occurs when ov && out_ready[cur_lane].
- **in_ready:** in_ready = !ov || out_ready[cur_lane]. It is combinational and depends only on the registered lane and out_ready, never on in_valid.
- **States:**
  - IDLE: the next accepted beat is the first beat of a burst.
  - BURST: a burst is open.
- **IDLE, on accept:**
  - lane_q <= in_sel.
  - beat_cnt <= 1.
  - If in_last or BURST_MAX==1, the beat terminates the burst and the state stays IDLE.
  - Otherwise the state goes to BURST.
- **BURST, on accept:**
  - The route uses lane_q; in_sel is ignored.
  - beat_cnt increments.
  - If in_last, return to IDLE.
  - Else if beat_cnt+1 == BURST_MAX, the beat is force-terminated: out_last=1 for that beat, burst_err pulses the cycle after acceptance, and the state returns to IDLE.
- **Routing:** the route for a beat is in_sel in IDLE and lane_q in BURST. It is decoded to one-hot by dec2to4.
- **On accept, the output register loads:**
  - out_valid <= onehot(route).
  - out_data <= in_data.
  - out_last <= in_last or the force-termination condition.
- **On drain without accept:** out_valid <= 0. out_data and out_last hold their values.
- **Drain and accept in the same cycle:** both occur; the register reloads with no bubble.
- **lane_cnt[k]:** increments on each drain of lane k and saturates at 2^CNT_W−1.

## Timing
- **Reset:** all of the following take effect asynchronously while rst_n=0.
  - out_valid=0, out_data=0, out_last=0, burst_err=0.
  - All lane_cnt=0.
  - State IDLE, beat_cnt=0, lane_q=0.
  - in_ready=1 once reset deasserts.
- **Latency:** one cycle from accept to out_valid.
- **Throughput:** one beat per cycle when the addressed sink holds out_ready=1.
- **Backpressure:**
  - While ov && !out_ready[cur_lane]: in_ready=0, and out_valid, out_data and out_last are stable.
  - out_ready bits of non-addressed lanes have no effect.
- **Lane switch:** a new burst to a different lane may be accepted in the same cycle the previous burst's last beat drains.
- **Reset mid-burst:** the open burst and any undelivered registered beat are discarded. The next accepted beat is a first beat.
- **burst_err:** high exactly one cycle, the cycle after the force-terminating beat is accepted.

## Structure
- **Package demux_pkg:**
  - NUM_LANES=4 and SEL_W=2.
  - State enum {IDLE, BURST}.
  - Default BURST_MAX constant.
- **Sub-module dec2to4:** combinational 2→4 one-hot decoder (inputs a,b; output y[3:0]), the same decode used on the mux side. It is instantiated once for routing.
- **Top:** the FSM, beat counter, output register and lane counters live in demux1x4_burst_router.

## Test plan
- **Reset values:** assert rst_n=0 with in_valid=1 → out_valid=0000, out_data=0, lane_cnt all 0; in_ready=1 after release.
- **Single-beat bursts:** beats 0x11 (sel=0,last), 0x22 (sel=3,last), with all out_ready=1. Expect out_valid=0001/0x11, then 1000/0x22 on consecutive cycles; lane_cnt[0]=1, lane_cnt[3]=1.
- **Burst holds its lane:** 3-beat burst with sel=2 on the first beat and sel=1 on beats 2–3 → all three beats appear on out_valid=0100; out_last=1 only on beat 3.
- **Backpressure:** with out_ready[2]=0 for 4 cycles during a lane-2 burst, in_ready=0 and out_data is stable. The beat delivers on the first cycle out_ready[2]=1, with no loss or duplication. Toggling out_ready[0] during this has no effect.
- **Overrun:** BURST_MAX=4 and 6 beats with no in_last, lane 1. Beat 4 carries out_last=1 and burst_err pulses once. Beat 5 is treated as a first beat and re-samples in_sel.
- **Reset mid-burst:** assert rst_n=0 after beat 2 of a lane-3 burst. Then send a beat with sel=0,last → it appears on lane 0, and lane_cnt[3] reads 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 burst router.
package demux_pkg;

  localparam int NUM_LANES     = 4;
  localparam int SEL_W         = 2;
  localparam int BURST_MAX_DEF = 15;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

endpackage

// File: rtl/dec2to4.sv
// 2-to-4 one-hot decoder; a is the select MSB.
module dec2to4 (
  input  logic       a,
  input  logic       b,
  output logic [3:0] y
);

  assign y = 4'b0001 << {a, b};

endmodule

// File: rtl/demux1x4_burst_router.sv
// Burst-locked 1-to-4 stream demux with one output register stage,
// per-lane delivered-beat counters and a burst overrun pulse.
module demux1x4_burst_router
  import demux_pkg::*;
#(
  parameter int DW        = 8,
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_data,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic                       in_last,
  output logic [NUM_LANES-1:0]       out_valid,
  input  logic [NUM_LANES-1:0]       out_ready,
  output logic [DW-1:0]              out_data,
  output logic                       out_last,
  output logic                       burst_err,
  output logic [NUM_LANES*CNT_W-1:0] lane_cnt
);

  state_t              state_q;
  state_t              state_d;
  logic [SEL_W-1:0]    lane_q;
  logic [SEL_W-1:0]    route;
  logic [NUM_LANES-1:0] route_oh;
  logic [7:0]          beat_cnt;
  logic                ov;
  logic                drain;
  logic                accept;
  logic                first;
  logic                term;
  logic                force_t;
  logic [CNT_W-1:0]    cnt_q [NUM_LANES];

  // out_valid is one-hot, so masking it with out_ready selects cur_lane
  assign ov       = |out_valid;
  assign drain    = |(out_valid & out_ready);
  assign in_ready = !ov || drain;
  assign accept   = in_valid && in_ready;
  assign first    = (state_q == IDLE);
  assign route    = first ? in_sel : lane_q;

  dec2to4 u_dec (
    .a (route[1]),
    .b (route[0]),
    .y (route_oh)
  );

  always_comb begin
    state_d = state_q;
    term    = 1'b0;
    force_t = 1'b0;
    if (accept) begin
      if (first)
        term = in_last || (BURST_MAX == 1);
      else
        term = in_last ||
          (({1'b0, beat_cnt} + 9'd1) == 9'(BURST_MAX));
      force_t = term && !in_last;
      state_d = term ? IDLE : BURST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      beat_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (first) begin
          lane_q   <= in_sel;
          beat_cnt <= 8'd1;
        end else begin
          beat_cnt <= beat_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      burst_err <= 1'b0;
    end else begin
      burst_err <= force_t;
      if (accept) begin
        out_valid <= route_oh;
        out_data  <= in_data;
        out_last  <= in_last || force_t;
      end else if (drain) begin
        out_valid <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_LANES; k++)
        cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++)
        if (out_valid[k] && out_ready[k] && cnt_q[k] != '1)
          cnt_q[k] <= cnt_q[k] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_cnt
    assign lane_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_demux1x4_burst_router.sv
// Directed and randomized checks of the burst router against a beat-level model.
module tb_demux1x4_burst_router;

  localparam int BM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_last;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        burst_err;
  logic [31:0] lane_cnt;

  int total = 0;
  int bad = 0;

  // model: the beat sitting in the output slot plus the open burst
  logic       m_pv;
  logic [1:0] m_pl;
  logic [7:0] m_pd;
  logic       m_plast;
  logic       m_err;
  int         m_cnt [4];
  logic       m_open;
  logic [1:0] m_lane;
  int         m_n;

  always #5 clk = ~clk;

  demux1x4_burst_router #(
    .DW(8), .BURST_MAX(BM), .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .burst_err (burst_err),
    .lane_cnt  (lane_cnt)
  );

  function automatic logic [3:0] exp_ov();
    return m_pv ? (4'b0001 << m_pl) : 4'b0000;
  endfunction

  function automatic logic exp_rdy();
    return !m_pv || out_ready[m_pl];
  endfunction

  task automatic model_reset();
    m_pv = 0; m_pl = 0; m_pd = 0; m_plast = 0; m_err = 0;
    m_open = 0; m_lane = 0; m_n = 0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
  endtask

  task automatic drive(input logic v, input logic [1:0] s,
                       input logic [7:0] d, input logic l,
                       input logic [3:0] r);
    in_valid = v; in_sel = s; in_data = d; in_last = l;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic advance();
    logic acc, dr, term, frc;
    acc = in_valid && exp_rdy();
    dr  = m_pv && out_ready[m_pl];
    frc = 0;
    if (dr && m_cnt[m_pl] < 255) m_cnt[m_pl]++;
    if (acc) begin
      if (!m_open) begin
        m_lane = in_sel;
        m_n = 1;
      end else begin
        m_n++;
      end
      term = in_last || (m_n == BM);
      frc = term && !in_last;
      m_open = !term;
      m_pv = 1; m_pl = m_lane; m_pd = in_data; m_plast = term;
    end else if (dr) begin
      m_pv = 0;
    end
    m_err = frc;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; in_data = 8'hFF; in_sel = 2;
    in_last = 0; out_ready = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 4'b0000) begin
      bad++; $display("FAIL reset_ov: got %b want 0000", out_valid);
    end
    total++;
    if (out_data !== 8'h00) begin
      bad++; $display("FAIL reset_data: got %h want 00", out_data);
    end
    total++;
    if (lane_cnt !== 32'h0 || burst_err !== 1'b0 || out_last !== 1'b0) begin
      bad++; $display("FAIL reset_cnt: got %h/%b/%b want 0", lane_cnt, burst_err, out_last);
    end
    rst_n = 1; in_valid = 0;
    model_reset();
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_rdy: got %b want 1", in_ready);
    end
    advance();
  endtask

  task automatic test_single();
    drive(1, 0, 8'h11, 1, 4'hF);
    advance();
    drive(1, 3, 8'h22, 1, 4'hF);
    total++;
    if (out_valid !== 4'b0001 || out_data !== 8'h11) begin
      bad++; $display("FAIL single_a: got %b/%h want 0001/11", out_valid, out_data);
    end
    advance();
    drive(0, 0, 8'h00, 0, 4'hF);
    total++;
    if (out_valid !== 4'b1000 || out_data !== 8'h22) begin
      bad++; $display("FAIL single_b: got %b/%h want 1000/22", out_valid, out_data);
    end
    advance();
    drive(0, 0, 8'h00, 0, 4'hF);
    total++;
    if (lane_cnt[7:0] !== 8'd1 || lane_cnt[31:24] !== 8'd1) begin
      bad++; $display("FAIL single_cnt: got %h want 01 and 01", lane_cnt);
    end
    advance();
  endtask

  task automatic test_hold();
    logic [1:0] sel;
    for (int i = 0; i < 4; i++) begin
      sel = (i == 0) ? 2'd2 : 2'd1;
      drive(i < 3, sel, 8'hA1 + 8'(i), i == 2, 4'hF);
      if (i > 0) begin
        total++;
        if (out_valid !== 4'b0100 || out_data !== 8'hA0 + 8'(i)) begin
          bad++; $display("FAIL hold_lane%0d: got %b/%h want 0100/%h",
                          i, out_valid, out_data, 8'hA0 + 8'(i));
        end
        total++;
        if (out_last !== (i == 3)) begin
          bad++; $display("FAIL hold_last%0d: got %b want %b", i, out_last, i == 3);
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    drive(1, 2, 8'hB1, 0, 4'hF);
    advance();
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 8'hB2, 1, {1'b1, 1'b0, 1'b1, 1'(c)});
      total++;
      if (in_ready !== 1'b0 || out_valid !== 4'b0100 || out_data !== 8'hB1) begin
        bad++; $display("FAIL bp_stall%0d: got %b/%b/%h want 0/0100/b1",
                        c, in_ready, out_valid, out_data);
      end
      advance();
    end
    drive(1, 0, 8'hB2, 1, 4'hF);
    total++;
    if (in_ready !== 1'b1 || out_data !== 8'hB1) begin
      bad++; $display("FAIL bp_release: got %b/%h want 1/b1", in_ready, out_data);
    end
    advance();
    drive(0, 0, 8'h00, 0, 4'hF);
    total++;
    if (out_valid !== 4'b0100 || out_data !== 8'hB2 || out_last !== 1'b1) begin
      bad++; $display("FAIL bp_next: got %b/%h/%b want 0100/b2/1",
                      out_valid, out_data, out_last);
    end
    advance();
    drive(0, 0, 8'h00, 0, 4'hF);
    total++;
    if (lane_cnt[23:16] !== 8'(m_cnt[2]) || out_valid !== 4'b0000) begin
      bad++; $display("FAIL bp_cnt: got %h/%b want %h/0000",
                      lane_cnt[23:16], out_valid, 8'(m_cnt[2]));
    end
    advance();
  endtask

  task automatic test_overrun();
    logic [1:0] sel;
    logic [3:0] want;
    int j;
    for (int i = 0; i < 7; i++) begin
      sel = (i == 0) ? 2'd1 : (i == 4) ? 2'd3 : 2'd0;
      drive(i < 6, sel, 8'hC0 + 8'(i), 0, 4'hF);
      if (i > 0) begin
        j = i - 1;
        want = (j < 4) ? 4'b0010 : 4'b1000;
        total++;
        if (out_valid !== want || out_data !== 8'hC0 + 8'(j)) begin
          bad++; $display("FAIL ovr_beat%0d: got %b/%h want %b/%h",
                          j, out_valid, out_data, want, 8'hC0 + 8'(j));
        end
        total++;
        if (out_last !== (j == 3) || burst_err !== (j == 3)) begin
          bad++; $display("FAIL ovr_flag%0d: got last=%b err=%b want %b",
                          j, out_last, burst_err, j == 3);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom),
            $urandom_range(0, 3) == 0,
            {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0});
      total++;
      if (in_ready !== exp_rdy()) begin
        bad++; $display("FAIL rnd_rdy@%0d: got %b want %b", i, in_ready, exp_rdy());
      end
      total++;
      if (out_valid !== exp_ov()) begin
        bad++; $display("FAIL rnd_ov@%0d: got %b want %b", i, out_valid, exp_ov());
      end
      if (m_pv) begin
        total++;
        if (out_data !== m_pd || out_last !== m_plast) begin
          bad++; $display("FAIL rnd_data@%0d: got %h/%b want %h/%b",
                          i, out_data, out_last, m_pd, m_plast);
        end
      end
      total++;
      if (burst_err !== m_err) begin
        bad++; $display("FAIL rnd_err@%0d: got %b want %b", i, burst_err, m_err);
      end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (lane_cnt[k*8 +: 8] !== 8'(m_cnt[k])) begin
          bad++; $display("FAIL rnd_cnt%0d@%0d: got %h want %h",
                          k, i, lane_cnt[k*8 +: 8], 8'(m_cnt[k]));
        end
      end
      advance();
    end
    drive(1, 0, 8'h00, 1, 4'hF);
    advance();
    drive(0, 0, 8'h00, 0, 4'hF);
    advance();
  endtask

  task automatic test_reset_mid();
    drive(1, 3, 8'hD1, 0, 4'hF);
    advance();
    drive(1, 1, 8'hD2, 0, 4'hF);
    advance();
    in_valid = 0;
    rst_n = 0;
    #2;
    total++;
    if (out_valid !== 4'b0000 || lane_cnt[31:24] !== 8'd0 || burst_err !== 1'b0) begin
      bad++; $display("FAIL rmid_async: got %b/%h/%b want 0000/00/0",
                      out_valid, lane_cnt[31:24], burst_err);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    drive(1, 0, 8'h5A, 1, 4'hF);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL rmid_rdy: got %b want 1", in_ready);
    end
    advance();
    drive(0, 0, 8'h00, 0, 4'hF);
    total++;
    if (out_valid !== 4'b0001 || out_data !== 8'h5A || out_last !== 1'b1) begin
      bad++; $display("FAIL rmid_beat: got %b/%h/%b want 0001/5a/1",
                      out_valid, out_data, out_last);
    end
    advance();
    drive(0, 0, 8'h00, 0, 4'hF);
    total++;
    if (lane_cnt[7:0] !== 8'd1 || lane_cnt[31:24] !== 8'd0) begin
      bad++; $display("FAIL rmid_cnt: got %h want lane0=01 lane3=00", lane_cnt);
    end
    advance();
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_backpressure();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
